// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared word sizes, loader state encoding and hold default
//
// Purpose: constants shared by the program loader and its users.
//   `ISIZE / `DSIZE : instruction-memory address and word widths
//   state_t         : loader FSM state encoding
//   HOLD_CYCLES_DEFAULT : cycles cpu_hold lingers after the last write
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   localparam int HOLD_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader into instruction memory
//
// Purpose: receives a word stream as byte pairs (high byte first) and writes
// each assembled word to consecutive instruction-memory addresses while the
// CPU fetch pipeline is held in reset.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start, base_addr, len : session request (sampled in IDLE)
//   abort           : terminate the current session
//   in_valid, in_data, in_ready : byte stream handshake
//   mem_wen, mem_addr, mem_data : registered memory write port
//   cpu_hold        : ORed into CPU reset while a session is active
//   busy, done, err : status; done/err are one-cycle pulses
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int AW          = `ISIZE,
   parameter int DW          = `DSIZE,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] len,
   input  logic          abort,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   state_t        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] count_q, count_d;
   logic [7:0]    hi_q, hi_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          wen_q, wen_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          cpu_hold_q, cpu_hold_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   assign in_ready = ((state_q == ST_HI) || (state_q == ST_LO)) && !abort;
   assign busy     = (state_q != ST_IDLE);
   assign mem_wen  = wen_q;
   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign err      = err_q;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      count_d = count_q;
      hi_d    = hi_q;
      hold_d  = hold_q;
      wen_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  base_d  = base_addr;
                  len_d   = len;
                  count_d = '0;
                  state_d = ST_HI;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_HI: begin
            if (abort) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (in_valid) begin
               hi_d    = in_data;
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            if (abort) begin
               // the half-received word in hi_q is simply abandoned
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (in_valid) begin
               // write port is registered so the write shows up in WRITE
               wen_d   = 1'b1;
               addr_d  = base_q + count_q;
               data_d  = DW'({hi_q, in_data});
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // the write itself already happened this cycle, even on abort
            count_d = count_q + AW'(1);
            if (abort) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (count_q + AW'(1) == len_q) begin
               hold_d  = '0;
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_HI;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // cpu_hold tracks the next state so it drops together with done/err
      cpu_hold_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         count_q    <= '0;
         hi_q       <= '0;
         hold_q     <= '0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         count_q    <= count_d;
         hi_q       <= hi_d;
         hold_q     <= hold_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;

   localparam int EV_W = 0;
   localparam int EV_D = 1;
   localparam int EV_E = 2;

   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [15:0] data;
      int          gap;
      bit          from_mark;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] len;
   logic        abort;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_wen;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   ev_t sb[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  mark_cyc = 0;
   int  last_evt_cyc = 0;

   prog_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int k, input logic [15:0] a, input logic [15:0] d,
                          input int gap, input bit fm);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d; e.gap = gap; e.from_mark = fm;
      sb.push_back(e);
   endtask

   task automatic handle(input int k);
      ev_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc);
      end else begin
         e = sb.pop_front();
         check("event_kind", k, e.kind);
         if (k == EV_W) begin
            check("write_addr", {16'h0, mem_addr}, {16'h0, e.addr});
            check("write_data", {16'h0, mem_data}, {16'h0, e.data});
         end else begin
            check("cpu_hold_low_at_end", {31'h0, cpu_hold}, 32'h0);
         end
         if (e.gap >= 0)
            check("event_gap", cyc - (e.from_mark ? mark_cyc : last_evt_cyc), e.gap);
      end
      last_evt_cyc = cyc;
   endtask

   // monitor: consumes expected events whenever the DUT presents one
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (done || err) check("done_err_exclusive", {31'h0, done & err}, 32'h0);
         if (mem_wen) handle(EV_W);
         if (done)    handle(EV_D);
         if (err)     handle(EV_E);
      end
   end

   task automatic do_start(input logic [15:0] b, input logic [15:0] l);
      start = 1'b1; base_addr = b; len = l; mark_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int n;
      in_valid = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("byte_accept_timeout", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input int limit);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
      check({tag, "_mem_wen"},  {31'h0, mem_wen},  32'h0);
      check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h0);
      check({tag, "_busy"},     {31'h0, busy},     32'h0);
      check({tag, "_done"},     {31'h0, done},     32'h0);
      check({tag, "_err"},      {31'h0, err},      32'h0);
      check({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
      check({tag, "_mem_data"}, {16'h0, mem_data}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t4_bytes [8];
      t4_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'hF0, 8'h0D};
      rst = 1'b0; start = 1'b0; base_addr = '0; len = '0;
      abort = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // back-to-back load of two words
      push_ev(EV_W, 16'h0010, 16'h1234, 3, 1'b1);
      push_ev(EV_W, 16'h0011, 16'hABCD, 3, 1'b0);
      push_ev(EV_D, 16'h0, 16'h0, 3, 1'b0);
      do_start(16'h0010, 16'd2);
      check("cpu_hold_after_start", {31'h0, cpu_hold}, 32'h1);
      check("busy_after_start", {31'h0, busy}, 32'h1);
      send_byte(8'h12, 0); send_byte(8'h34, 0);
      send_byte(8'hAB, 0); send_byte(8'hCD, 0);
      wait_empty(50);

      // zero-length start
      push_ev(EV_E, 16'h0, 16'h0, 1, 1'b1);
      do_start(16'h0055, 16'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("len0_busy", {31'h0, busy}, 32'h0);
         check("len0_cpu_hold", {31'h0, cpu_hold}, 32'h0);
      end
      wait_empty(20);

      // address wrap at the top of memory
      push_ev(EV_W, 16'hFFFF, 16'h0001, 3, 1'b1);
      push_ev(EV_W, 16'h0000, 16'h0002, 3, 1'b0);
      push_ev(EV_D, 16'h0, 16'h0, 3, 1'b0);
      do_start(16'hFFFF, 16'd2);
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      wait_empty(50);

      // stalled stream, four words
      push_ev(EV_W, 16'h0100, 16'hDEAD, -1, 1'b0);
      push_ev(EV_W, 16'h0101, 16'hBEEF, -1, 1'b0);
      push_ev(EV_W, 16'h0102, 16'h0102, -1, 1'b0);
      push_ev(EV_W, 16'h0103, 16'hF00D, -1, 1'b0);
      push_ev(EV_D, 16'h0, 16'h0, 3, 1'b0);
      do_start(16'h0100, 16'd4);
      for (int i = 0; i < 8; i++) send_byte(t4_bytes[i], int'($urandom_range(0, 3)));
      wait_empty(80);

      // abort while waiting for the low byte of word 2
      push_ev(EV_W, 16'h0200, 16'h5566, 3, 1'b1);
      do_start(16'h0200, 16'd3);
      send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
      wait_empty(10);
      push_ev(EV_E, 16'h0, 16'h0, 1, 1'b1);
      abort = 1'b1; in_valid = 1'b1; in_data = 8'h88; mark_cyc = cyc;
      @(negedge clk);
      check("no_accept_on_abort", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      check("abort_cpu_hold", {31'h0, cpu_hold}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      wait_empty(20);
      repeat (4) @(posedge clk);
      #1;
      push_ev(EV_W, 16'h0300, 16'h9ABC, 3, 1'b1);
      push_ev(EV_D, 16'h0, 16'h0, 3, 1'b0);
      do_start(16'h0300, 16'd1);
      send_byte(8'h9A, 0); send_byte(8'hBC, 0);
      wait_empty(40);

      // asynchronous reset in LO
      do_start(16'h0400, 16'd2);
      send_byte(8'h11, 0);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      in_valid = 1'b1; in_data = 8'h22;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = i[0];
         in_data  = 8'h30 + 8'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("post_rst_busy", {31'h0, busy}, 32'h0);
      check("post_rst_mem_wen", {31'h0, mem_wen}, 32'h0);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty_final", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: AW, default `ISIZE (16), memory address width.
REQ-002 Parameter: DW, default `DSIZE (16), memory word width; fixed at two bytes.
REQ-003 Parameter: HOLD_CYCLES, default 2, cycles cpu_hold stays high after the last write.
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  begin a load session; sampled only in IDLE.
REQ-007 Port: base_addr  in  AW  first word address; captured on start.
REQ-008 Port: len  in  AW  number of words to load; captured on start.
REQ-009 Port: abort  in  1  terminate the session.
REQ-010 Port: in_valid  in  1  byte-stream valid.
REQ-011 Port: in_data  in  8  byte; high byte of each word first.
REQ-012 Port: in_ready  out  1  loader accepts a byte this cycle.
REQ-013 Port: mem_wen  out  1  instruction-memory write enable.
REQ-014 Port: mem_addr  out  AW  write address.
REQ-015 Port: mem_data  out  DW  write data.
REQ-016 Port: cpu_hold  out  1  holds the fetch pipeline in reset while loading.
REQ-017 Port: busy  out  1  high in every state except IDLE.
REQ-018 Port: done  out  1  one-cycle pulse on successful completion.
REQ-019 Port: err  out  1  one-cycle pulse on len==0 start or abort.

Function
REQ-020 States: IDLE, HI, LO, WRITE, DRAIN.
REQ-021 IDLE with start=1 and len!=0: capture base_addr/len, clear word count, go to HI; cpu_hold=1 from the next cycle.
REQ-022 IDLE with start=1 and len==0: err=1 next cycle, stay IDLE, no write, cpu_hold stays 0.
REQ-023 start outside IDLE is ignored.
REQ-024 in_ready=1 only in HI and LO with abort=0; a byte transfers when in_valid&in_ready.
REQ-025 HI, transfer: latch in_data as word[15:8], go to LO; LO, transfer: latch word[7:0], go to WRITE.
REQ-026 WRITE lasts one cycle: mem_wen=1, mem_addr=(base+count) mod 2^AW, mem_data=assembled word; count increments.
REQ-027 WRITE exit: go to DRAIN if the written word was number len (count reaches len), else go to HI.
REQ-028 mem_wen, mem_addr and mem_data are registered; mem_wen is 0 outside WRITE, while mem_addr/mem_data hold their last values.
REQ-029 Throughput: at most one word per 3 cycles. Latency: mem_wen 1 cycle after the low-byte transfer.
REQ-030 In HI or LO with in_valid=0: wait indefinitely; no timeout.
REQ-031 DRAIN counts HOLD_CYCLES cycles, then enters IDLE with done=1 and cpu_hold=0 in that same cycle.
REQ-032 abort=1 in HI, LO, WRITE or DRAIN: enter IDLE next cycle with err=1 and cpu_hold=0. No byte is accepted that cycle. A WRITE coinciding with abort still completes its single write.
REQ-033 A partially received word, low byte missing, is discarded on abort.
REQ-034 done and err are never asserted in the same cycle.

Reset
REQ-035 rst=0 immediately forces IDLE and count=0, with in_ready, mem_wen, cpu_hold, busy, done and err at 0 and mem_addr, mem_data at 0.
REQ-036 Reset mid-session discards all partial state; no write is issued after reset deasserts until a new start.

Structure
REQ-037 AW/DW come from the shared define file (`ISIZE, `DSIZE); state encodings and the HOLD_CYCLES default go in the shared constants file.
REQ-038 Single module, no sub-modules; mem_* ports connect to the instruction memory write port (wen/addr/data_in), and cpu_hold is ORed into the CPU reset.

Verification
REQ-039 base=0x0010, len=2, bytes 12,34,AB,CD back-to-back: writes (0x0010,0x1234) then (0x0011,0xABCD), 3 cycles apart; done 3 cycles after the second mem_wen; cpu_hold low with done.
REQ-040 start with len=0: err one cycle later, mem_wen never 1, busy and cpu_hold stay 0.
REQ-041 base=0xFFFF, len=2, bytes 00,01,00,02: writes (0xFFFF,0x0001), (0x0000,0x0002).
REQ-042 in_valid toggled pseudo-randomly, len=4: same four addresses and words as the stall-free run; no byte lost or duplicated.
REQ-043 abort in LO of word 2 (len=3): only one write; err one cycle; cpu_hold 0 next cycle; a later start loads normally.
REQ-044 rst pulled low in LO: all outputs 0 without a clock edge; after release, no mem_wen until a new start.
